// File: rtl/wb_arbiter.sv
// Write-back arbiter: owns the single register-file write port, merging ALU results
// with buffered load results while keeping program order on same-register collisions.
module wb_arbiter #(
    parameter int REG_FILE_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH          = 32,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              alu_valid,
    input  logic [REG_FILE_ADDR_WIDTH-1:0]    alu_rd,
    input  logic [DATA_WIDTH-1:0]             alu_result,
    input  logic                              mem_valid,
    output logic                              mem_ready,
    input  logic [REG_FILE_ADDR_WIDTH-1:0]    mem_rd,
    input  logic [DATA_WIDTH-1:0]             mem_data,
    output logic [REG_FILE_ADDR_WIDTH-1:0]    AD3,
    output logic                              WE3,
    output logic [DATA_WIDTH-1:0]             WD3,
    output logic [2**REG_FILE_ADDR_WIDTH-1:0] pending,
    output logic [DATA_WIDTH-1:0]             a0
);
    localparam int AW   = REG_FILE_ADDR_WIDTH;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 2**AW;

    logic [AW-1:0]         r_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_kill;
    logic [PW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_cnt;

    logic                  w_full, w_empty, w_alu, w_push, w_pop, w_same;
    logic                  w_we;
    logic [AW-1:0]         w_ad;
    logic [DATA_WIDTH-1:0] w_wd;
    logic [FIFO_DEPTH-1:0] w_occ;
    logic [NREG-1:0]       w_pend;

    assign w_full    = (r_cnt == CW'(FIFO_DEPTH));
    assign w_empty   = (r_cnt == '0);
    assign mem_ready = !rst && !w_full;
    assign w_alu     = alu_valid && (alu_rd != '0);
    assign w_push    = mem_valid && mem_ready && (mem_rd != '0);
    // ALU always owns the port; loads drain only on ALU-idle cycles.
    assign w_pop     = !w_alu && !w_empty;
    // A load landing alongside an ALU write to the same rd is the older of the two.
    assign w_same    = w_alu && (mem_rd == alu_rd);

    always_comb begin
        w_we = 1'b0;
        w_ad = AD3;
        w_wd = WD3;
        if (w_alu) begin
            w_we = 1'b1;
            w_ad = alu_rd;
            w_wd = alu_result;
        end else if (w_pop && !r_kill[r_rptr]) begin
            w_we = 1'b1;
            w_ad = r_rd[r_rptr];
            w_wd = r_data[r_rptr];
        end
    end

    always_comb begin
        logic [PW-1:0] off;
        w_occ  = '0;
        w_pend = '0;
        off    = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            off      = PW'(i) - r_rptr;
            w_occ[i] = ({1'b0, off} < r_cnt);
            if (w_occ[i] && !r_kill[i])
                w_pend[r_rd[i]] = 1'b1;
        end
        w_pend[0] = 1'b0;
    end
    assign pending = w_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_kill <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                if (w_alu && r_rd[i] == alu_rd)
                    r_kill[i] <= 1'b1;
            if (w_push) begin
                r_rd[r_wptr]   <= mem_rd;
                r_data[r_wptr] <= mem_data;
                r_kill[r_wptr] <= w_same;
                r_wptr         <= r_wptr + PW'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            WE3 <= 1'b0;
            AD3 <= '0;
            WD3 <= '0;
            a0  <= '0;
        end else begin
            WE3 <= w_we;
            AD3 <= w_ad;
            WD3 <= w_wd;
            if (w_we && w_ad == AW'(10))
                a0 <= w_wd;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: inputs change 1ns after the rising edge,
// registered outputs are sampled 1ns after the edge that loads them.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic [4:0]  AD3;
    logic        WE3;
    logic [31:0] WD3;
    logic [31:0] pending;
    logic [31:0] a0;

    int passed = 0;
    int total  = 0;

    wb_arbiter #(.REG_FILE_ADDR_WIDTH(5), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .AD3(AD3), .WE3(WE3), .WD3(WD3), .pending(pending), .a0(a0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] ad, input logic [31:0] wd);
        chk({tag, ".we"}, 64'(WE3), 64'(we));
        chk({tag, ".ad"}, 64'(AD3), 64'(ad));
        chk({tag, ".wd"}, 64'(WD3), 64'(wd));
    endtask

    initial begin
        rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        step();
        step();
        chk("rst.mem_ready", 64'(mem_ready), 64'd0);
        chk_wr("rst", 1'b0, 5'd0, 32'd0);
        chk("rst.a0", 64'(a0), 64'd0);
        chk("rst.pending", 64'(pending), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst.mem_ready", 64'(mem_ready), 64'd1);

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'h1234;
        step();
        chk_wr("alu5", 1'b1, 5'd5, 32'h1234);
        alu_rd = 5'd0; alu_result = 32'h9999;
        step();
        chk_wr("alu0", 1'b0, 5'd5, 32'h1234);
        alu_valid = 1'b0;

        // Load only, into a0
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hCAFE;
        #1;
        chk("ld10.pend_pre", 64'(pending), 64'd0);
        step();
        mem_valid = 1'b0;
        chk("ld10.pend_q", 64'(pending), 64'(32'h1 << 10));
        chk("ld10.we_q", 64'(WE3), 64'd0);
        step();
        chk_wr("ld10", 1'b1, 5'd10, 32'hCAFE);
        chk("ld10.a0", 64'(a0), 64'hCAFE);
        chk("ld10.pend_post", 64'(pending), 64'd0);

        // Load to x0 completes the handshake but is never written
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hDEAD;
        step();
        mem_valid = 1'b0;
        chk("ld0.pend", 64'(pending), 64'd0);
        step();
        chk("ld0.we", 64'(WE3), 64'd0);

        // Back-pressure: ALU holds the port while five loads are offered
        alu_valid = 1'b1; mem_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            alu_rd = 5'(k + 1); alu_result = 32'(k + 1);
            mem_rd = 5'(11 + k); mem_data = 32'h100 + 32'(k);
            #1;
            chk($sformatf("bp.ready%0d", k), 64'(mem_ready), (k < 4) ? 64'd1 : 64'd0);
            step();
            chk_wr($sformatf("bp.alu%0d", k), 1'b1, 5'(k + 1), 32'(k + 1));
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        chk("bp.pend_full", 64'(pending), 64'h0000_7800);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_wr($sformatf("bp.drain%0d", k), 1'b1, 5'(11 + k), 32'h100 + 32'(k));
        end
        chk("bp.ready_after", 64'(mem_ready), 64'd1);
        chk("bp.pend_after", 64'(pending), 64'd0);

        // Kill: buffered load to x7 overtaken by a younger ALU write
        alu_valid = 1'b1; alu_rd = 5'd1; alu_result = 32'h55;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'hAA;
        step();
        mem_valid = 1'b0;
        chk("kill.pend_q", 64'(pending), 64'(32'h1 << 7));
        alu_rd = 5'd7; alu_result = 32'hBB;
        step();
        alu_valid = 1'b0;
        chk_wr("kill.alu", 1'b1, 5'd7, 32'hBB);
        chk("kill.pend", 64'(pending), 64'd0);
        step();
        chk_wr("kill.pop", 1'b0, 5'd7, 32'hBB);
        step();
        chk("kill.idle", 64'(WE3), 64'd0);

        // Same-cycle collision on x3
        alu_valid = 1'b1; alu_rd = 5'd3; alu_result = 32'h22;
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk_wr("coll.alu", 1'b1, 5'd3, 32'h22);
        chk("coll.pend", 64'(pending), 64'd0);
        step();
        chk_wr("coll.pop", 1'b0, 5'd3, 32'h22);
        step();
        chk("coll.idle", 64'(WE3), 64'd0);

        // Reset mid-stream with three queued loads
        alu_valid = 1'b1; mem_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            alu_rd = 5'(2 + k); alu_result = 32'(k);
            mem_rd = 5'(20 + k); mem_data = 32'h300 + 32'(k);
            step();
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("mrst.pend_q", 64'(pending), 64'h0070_0000);
        rst = 1'b1;
        #1;
        chk("mrst.ready", 64'(mem_ready), 64'd0);
        step();
        rst = 1'b0;
        chk_wr("mrst", 1'b0, 5'd0, 32'd0);
        chk("mrst.pend", 64'(pending), 64'd0);
        chk("mrst.a0", 64'(a0), 64'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("mrst.stale%0d", k), 64'(WE3), 64'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
